// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm compare, ring/snooze/dismiss sequencing and gated buzzer tone
module alarm_trigger #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int TONE_DIV   = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic [47:0] cur_time,
    input  logic [47:0] bin_alarm,
    input  logic        set_alarm,
    input  logic [3:0]  sw_in,
    output logic        armed,
    output logic        ringing,
    output logic        buzzer,
    output logic        alarm_event,
    output logic [1:0]  snooze_cnt
);

    localparam int                TONE_W     = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [7:0]        RING_LOAD  = 8'(RING_SEC);
    localparam logic [8:0]        SNZ_LOAD   = 9'(SNOOZE_SEC);
    localparam logic [1:0]        SNZ_MAX    = 2'(MAX_SNOOZE);
    localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
    localparam logic [3:0]        SW_SNOOZE  = 4'b0010;
    localparam logic [3:0]        SW_DISMISS = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RINGING,
        S_SNOOZE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                tick_q;
    logic                match_q;
    logic [7:0]          ring_cnt_q, ring_cnt_d;
    logic [8:0]          snz_cnt_q, snz_cnt_d;
    logic [1:0]          snooze_cnt_q, snooze_cnt_d;
    logic                beep_q, beep_d;
    logic                tone_q, tone_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                armed_q, armed_d;
    logic                ringing_q, ringing_d;
    logic                buzzer_q, buzzer_d;
    logic                event_q, event_d;
    logic                enter_ring;

    logic tick;
    logic match;
    logic hit;
    logic btn_snooze;
    logic btn_dismiss;

    // A second starts on the clk where clk1sec is first seen high; a trigger only on match entry
    assign tick        = clk1sec & ~tick_q;
    assign match       = (cur_time == bin_alarm);
    assign hit         = match & ~match_q;
    assign btn_snooze  = (sw_in == SW_SNOOZE);
    assign btn_dismiss = (sw_in == SW_DISMISS);

    // Next-state, counters and registered-output values in priority order: cancel, dismiss, snooze, tick, hit
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_d       = beep_q;
        tone_d       = tone_q;
        tone_cnt_d   = tone_cnt_q;
        enter_ring   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (set_alarm && (bin_alarm != 48'd0)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!set_alarm) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    enter_ring = 1'b1;
                end
            end
            S_RINGING: begin
                if (!set_alarm) begin
                    state_d = S_IDLE;
                end else if (btn_dismiss) begin
                    state_d = S_DONE;
                end else if (btn_snooze && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = S_SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                    snz_cnt_d    = SNZ_LOAD;
                end else if (tick) begin
                    // ring_cnt is never 0 here: it is loaded with RING_SEC >= 1 on entry
                    ring_cnt_d = ring_cnt_q - 8'd1;
                    beep_d     = ~beep_q;
                    if (ring_cnt_q == 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SNOOZE: begin
                if (!set_alarm) begin
                    state_d = S_IDLE;
                end else if (btn_dismiss) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    snz_cnt_d = snz_cnt_q - 9'd1;
                    if (snz_cnt_q == 9'd1) begin
                        enter_ring = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Interlock: a still-held set_alarm must be released before re-arming
                if (!set_alarm) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            snooze_cnt_d = 2'd0;
        end

        // Tone divider runs only while staying in RINGING; parked at 0 otherwise
        if ((state_q == S_RINGING) && (state_d == S_RINGING)) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
            end
        end else begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end

        if (enter_ring) begin
            state_d    = S_RINGING;
            ring_cnt_d = RING_LOAD;
            beep_d     = 1'b1;
            tone_d     = 1'b0;
            tone_cnt_d = '0;
        end

        armed_d   = (state_d == S_ARMED) || (state_d == S_RINGING) || (state_d == S_SNOOZE);
        ringing_d = (state_d == S_RINGING);
        buzzer_d  = ringing_d & beep_d & tone_d;
        event_d   = enter_ring;
    end

    // State, counters, edge detectors and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= 1'b0;
            match_q      <= 1'b0;
            ring_cnt_q   <= 8'd0;
            snz_cnt_q    <= 9'd0;
            snooze_cnt_q <= 2'd0;
            beep_q       <= 1'b0;
            tone_q       <= 1'b0;
            tone_cnt_q   <= '0;
            armed_q      <= 1'b0;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
            event_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= clk1sec;
            match_q      <= match;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            beep_q       <= beep_d;
            tone_q       <= tone_d;
            tone_cnt_q   <= tone_cnt_d;
            armed_q      <= armed_d;
            ringing_q    <= ringing_d;
            buzzer_q     <= buzzer_d;
            event_q      <= event_d;
        end
    end

    assign armed       = armed_q;
    assign ringing     = ringing_q;
    assign buzzer      = buzzer_q;
    assign alarm_event = event_q;
    assign snooze_cnt  = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - randomized scenario bench for alarm_trigger against a behavioural model
module tb_alarm_trigger;

    localparam int RING_SEC   = 5;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;
    localparam int TONE_DIV   = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;
    localparam int M_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk1sec = 1'b0;
    logic [47:0] cur_time = '0;
    logic [47:0] bin_alarm = '0;
    logic        set_alarm = 1'b0;
    logic [3:0]  sw_in = 4'h0;
    logic        armed;
    logic        ringing;
    logic        buzzer;
    logic        alarm_event;
    logic [1:0]  snooze_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model: elapsed-time view of the alarm episode
    int m_mode = M_IDLE;
    int m_snoozes = 0;
    int m_ticks = 0;
    int m_cyc = 0;
    int m_snz_left = 0;
    bit m_prev_sec = 1'b0;
    bit m_prev_match = 1'b0;
    bit m_event = 1'b0;

    int per = 8;
    int ph = 0;
    int n_ticks = 0;
    int dut_ev = 0;

    wire [5:0] dut_v = {armed, ringing, buzzer, alarm_event, snooze_cnt};

    alarm_trigger #(
        .RING_SEC(RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE),
        .TONE_DIV(TONE_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk1sec(clk1sec),
        .cur_time(cur_time),
        .bin_alarm(bin_alarm),
        .set_alarm(set_alarm),
        .sw_in(sw_in),
        .armed(armed),
        .ringing(ringing),
        .buzzer(buzzer),
        .alarm_event(alarm_event),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] mdl_v();
        logic ar, rg, bz;
        ar = (m_mode == M_ARMED) || (m_mode == M_RING) || (m_mode == M_SNZ);
        rg = (m_mode == M_RING);
        bz = rg && ((m_ticks % 2) == 0) && (((m_cyc / TONE_DIV) % 2) == 1);
        return {ar, rg, bz, m_event, 2'(m_snoozes)};
    endfunction

    task automatic model_edge();
        bit tick, hit, mt, enter;
        int nxt;
        mt    = (cur_time == bin_alarm);
        tick  = clk1sec && !m_prev_sec;
        hit   = mt && !m_prev_match;
        enter = 1'b0;
        m_event = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_snoozes = 0; m_ticks = 0; m_cyc = 0; m_snz_left = 0;
            m_prev_sec = 1'b0; m_prev_match = 1'b0;
            return;
        end
        m_prev_sec   = clk1sec;
        m_prev_match = mt;
        nxt = m_mode;
        case (m_mode)
            M_IDLE:  if (set_alarm && bin_alarm != 48'd0) nxt = M_ARMED;
            M_ARMED: if (!set_alarm) nxt = M_IDLE; else if (hit) enter = 1'b1;
            M_RING: begin
                if (!set_alarm) nxt = M_IDLE;
                else if (sw_in == 4'b0001) nxt = M_DONE;
                else if (sw_in == 4'b0010 && m_snoozes < MAX_SNOOZE) begin
                    nxt = M_SNZ; m_snoozes++; m_snz_left = SNOOZE_SEC;
                end else begin
                    m_cyc++;
                    if (tick) begin
                        m_ticks++;
                        if (m_ticks == RING_SEC) nxt = M_DONE;
                    end
                end
            end
            M_SNZ: begin
                if (!set_alarm) nxt = M_IDLE;
                else if (sw_in == 4'b0001) nxt = M_DONE;
                else if (tick) begin
                    m_snz_left--;
                    if (m_snz_left == 0) enter = 1'b1;
                end
            end
            default: if (!set_alarm) nxt = M_IDLE;
        endcase
        if (nxt == M_IDLE || nxt == M_DONE) m_snoozes = 0;
        if (enter) begin
            nxt = M_RING; m_ticks = 0; m_cyc = 0; m_event = 1'b1;
        end
        m_mode = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (alarm_event === 1'b1) dut_ev++;
    endtask

    // one clk with the 1 Hz square wave advanced; each second has a random length
    task automatic cyc();
        if (ph == 0) begin
            per = $urandom_range(6, 12);
            n_ticks++;
        end
        clk1sec = (ph < per / 2);
        ph = (ph + 1) % per;
        step();
    endtask

    task automatic trigger();
        sw_in = 4'h0; set_alarm = 1'b0; cyc();
        set_alarm = 1'b1; cur_time = bin_alarm - 48'h1; cyc();
        cur_time = bin_alarm; cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; set_alarm = 1'b0; sw_in = 4'h0;
        cyc(); cyc();
        n_checks++;
        if (dut_v !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 000000", dut_v); end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL reset_release: got %b expected %b", dut_v, mdl_v()); end
    endtask

    task automatic test_arm_trigger();
        int off, ev0, rises;
        logic pb;
        bin_alarm = 48'h18_03_0F_0A_1E_00;
        off = $urandom_range(4, 20);
        cur_time = bin_alarm - 48'(off);
        set_alarm = 1'b1;
        cyc();
        n_checks++;
        if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_after_1clk: got %b expected 1", armed); end
        ev0 = dut_ev;
        while (cur_time != bin_alarm) begin
            cur_time = cur_time + 48'h1;
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL approach: got %b expected %b", dut_v, mdl_v()); end
        end
        n_checks++;
        if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_on_match: got %b expected 1", ringing); end
        rises = 0; pb = buzzer;
        for (int i = 0; i < 300 && m_mode != M_DONE; i++) begin
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL ring_cycle %0d: got %b expected %b", i, dut_v, mdl_v()); end
            if (buzzer === 1'b1 && pb !== 1'b1) rises++;
            pb = buzzer;
        end
        n_checks++;
        if (dut_ev - ev0 != 1) begin n_fail++; $display("FAIL one_event: got %0d expected 1", dut_ev - ev0); end
        n_checks++;
        if (rises == 0) begin n_fail++; $display("FAIL buzzer_active: got %0d rises expected >0", rises); end
        n_checks++;
        if ({armed, ringing} !== 2'b00) begin n_fail++; $display("FAIL ring_timeout_done: got %b expected 00", {armed, ringing}); end
    endtask

    task automatic test_hold_match();
        int ev0, t0;
        set_alarm = 1'b0; cyc();
        bin_alarm = 48'h0; cur_time = 48'h0; set_alarm = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL zero_alarm_not_armed: got %b expected 0", armed); end
        set_alarm = 1'b0; cyc();
        bin_alarm = {16'($urandom), 32'($urandom)} | 48'h1;
        cur_time = bin_alarm; cyc();
        set_alarm = 1'b1; ev0 = dut_ev; t0 = n_ticks;
        for (int i = 0; i < 200 && n_ticks - t0 < 4; i++) begin
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL arm_while_match: got %b expected %b", dut_v, mdl_v()); end
        end
        n_checks++;
        if ({armed, ringing, 32'(dut_ev - ev0)} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL no_trigger_on_held_match: armed=%b ringing=%b events=%0d expected 1 0 0", armed, ringing, dut_ev - ev0);
        end
        cur_time = bin_alarm ^ 48'h1; cyc();
        cur_time = bin_alarm; ev0 = dut_ev; t0 = n_ticks;
        for (int i = 0; i < 400 && n_ticks - t0 < 10; i++) begin
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL hold_match: got %b expected %b", dut_v, mdl_v()); end
        end
        n_checks++;
        if (dut_ev - ev0 != 1) begin n_fail++; $display("FAIL hold_one_event: got %0d expected 1", dut_ev - ev0); end
    endtask

    task automatic test_snooze();
        int t0, ev0;
        bin_alarm = 48'h18_03_0F_0A_1E_00;
        trigger();
        n_checks++;
        if ({ringing, snooze_cnt} !== 3'b100) begin n_fail++; $display("FAIL snooze_start: got %b expected 100", {ringing, snooze_cnt}); end
        for (int k = 1; k <= 2; k++) begin
            repeat ($urandom_range(1, 5)) cyc();
            sw_in = 4'b0010; cyc(); sw_in = 4'h0;
            n_checks++;
            if ({armed, ringing, snooze_cnt} !== {2'b10, 2'(k)}) begin
                n_fail++; $display("FAIL snooze_%0d: got %b expected %b", k, {armed, ringing, snooze_cnt}, {2'b10, 2'(k)});
            end
            t0 = n_ticks; ev0 = dut_ev;
            for (int i = 0; i < 200 && m_mode != M_RING; i++) begin
                cyc();
                n_checks++;
                if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL snooze_wait: got %b expected %b", dut_v, mdl_v()); end
            end
            n_checks++;
            if ({ringing, 32'(n_ticks - t0), 32'(dut_ev - ev0)} !== {1'b1, 32'(SNOOZE_SEC), 32'd1}) begin
                n_fail++; $display("FAIL rering_%0d: ringing=%b ticks=%0d events=%0d expected 1 %0d 1", k, ringing, n_ticks - t0, dut_ev - ev0, SNOOZE_SEC);
            end
        end
        repeat ($urandom_range(1, 5)) cyc();
        sw_in = 4'b0010; cyc(); sw_in = 4'h0;
        n_checks++;
        if ({ringing, snooze_cnt} !== 3'b110) begin n_fail++; $display("FAIL snooze_limit: got %b expected 110", {ringing, snooze_cnt}); end
    endtask

    task automatic test_dismiss_interlock();
        trigger();
        repeat ($urandom_range(1, 8)) cyc();
        sw_in = 4'b0001; cyc(); sw_in = 4'h0;
        n_checks++;
        if ({armed, ringing, snooze_cnt} !== 4'b0000) begin n_fail++; $display("FAIL dismiss: got %b expected 0000", {armed, ringing, snooze_cnt}); end
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_checks++;
            if (armed !== 1'b0) begin n_fail++; $display("FAIL interlock_hold %0d: got %b expected 0", i, armed); end
        end
        set_alarm = 1'b0; cyc();
        n_checks++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL interlock_release: got %b expected 0", armed); end
        set_alarm = 1'b1; cyc();
        n_checks++;
        if (armed !== 1'b1) begin n_fail++; $display("FAIL rearm: got %b expected 1", armed); end
    endtask

    task automatic test_cancel_reset();
        int i;
        trigger();
        cyc();
        sw_in = 4'b0010; cyc(); sw_in = 4'h0;
        n_checks++;
        if ({armed, ringing, snooze_cnt} !== 4'b1001) begin n_fail++; $display("FAIL cancel_setup: got %b expected 1001", {armed, ringing, snooze_cnt}); end
        set_alarm = 1'b0; cyc();
        n_checks++;
        if ({armed, snooze_cnt} !== 3'b000) begin n_fail++; $display("FAIL cancel_snooze: got %b expected 000", {armed, snooze_cnt}); end
        trigger();
        for (i = 0; i < 100 && buzzer !== 1'b1; i++) cyc();
        n_checks++;
        if (buzzer !== 1'b1) begin n_fail++; $display("FAIL buzzer_timeout: got %b expected 1 within 100 clk", buzzer); end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_checks++;
        if (dut_v !== 6'b0) begin n_fail++; $display("FAIL reset_mid_ring: got %b expected 000000", dut_v); end
    endtask

    task automatic test_conflicts();
        int ev0, t0;
        set_alarm = 1'b1;
        trigger();
        for (int i = 0; i < 300 && !(m_mode == M_RING && m_ticks == RING_SEC - 1 && ph == 0); i++) begin
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL to_final_tick: got %b expected %b", dut_v, mdl_v()); end
        end
        ev0 = dut_ev;
        sw_in = 4'b0001; cyc(); sw_in = 4'h0;
        repeat (20) cyc();
        n_checks++;
        if ({armed, ringing, 32'(dut_ev - ev0)} !== {2'b00, 32'd0}) begin
            n_fail++; $display("FAIL dismiss_on_final_tick: armed=%b ringing=%b events=%0d expected 0 0 0", armed, ringing, dut_ev - ev0);
        end
        trigger();
        for (int i = 0; i < 20 && ph != 0; i++) cyc();
        sw_in = 4'b0010; cyc(); sw_in = 4'h0;
        n_checks++;
        if ({ringing, snooze_cnt} !== 3'b001) begin n_fail++; $display("FAIL snooze_on_tick: got %b expected 001", {ringing, snooze_cnt}); end
        t0 = n_ticks;
        for (int i = 0; i < 200 && m_mode != M_RING; i++) cyc();
        n_checks++;
        if ({ringing, 32'(n_ticks - t0)} !== {1'b1, 32'(SNOOZE_SEC)}) begin
            n_fail++; $display("FAIL snooze_len_after_tick: ringing=%b ticks=%0d expected 1 %0d", ringing, n_ticks - t0, SNOOZE_SEC);
        end
    endtask

    task automatic test_random();
        int r, r2;
        bin_alarm = 48'h18_03_0F_0A_1E_00;
        set_alarm = 1'b1;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            sw_in = (r < 4) ? 4'b0010 : (r < 6) ? 4'b0001 : (r < 8) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 79) == 0) set_alarm = ~set_alarm;
            rst = ($urandom_range(0, 299) == 0);
            r2 = $urandom_range(0, 29);
            cur_time = (r2 == 0) ? bin_alarm : bin_alarm + 48'(r2);
            cyc();
            n_checks++;
            if (dut_v !== mdl_v()) begin n_fail++; $display("FAIL random %0d: got %b expected %b", i, dut_v, mdl_v()); end
        end
        rst = 1'b0; sw_in = 4'h0;
    endtask

    initial begin
        test_reset();
        test_arm_trigger();
        test_hold_match();
        test_snooze();
        test_dismiss_interlock();
        test_cancel_reset();
        test_conflicts();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
